fu_branch_pipe: RTL and testbench
=================================

# fu_branch_pipe

Pipelined, parametrised branch/jump resolution unit for the execute stage. It accepts branch and jump micro-ops with a valid/ready handshake and resolves outcome, target and misprediction in one registered stage. Results are held in a DEPTH-entry in-order result queue and drained by writeback/commit under its own handshake. The unit issues exactly one BTB update per conditional branch and squashes younger queued results on a mispredict or an external flush.

## Interface
- XLEN, 32: datapath width (PC, operands, immediate).
- DEPTH, 4: result queue entries; power of two, ≥2.
- TAGW, 4: width of the instruction tag carried through.
- CLK  in  1  clock.
- nRST  in  1  asynchronous, active-low reset.
- flush  in  1  external pipeline flush; empties the queue.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept this cycle.
- in_tag  in  TAGW  instruction tag.
- in_pc  in  XLEN  PC of the op.
- in_reg_a, in_reg_b  in  XLEN  source operands.
- in_imm  in  XLEN  decoded, sign-extended immediate.
- in_branch_type  in  3  isa_pkg branch type (BT_BEQ..BT_BGEU).
- in_j_type  in  2  0 = conditional branch, 1 = JAL, 2 = JALR, 3 = reserved.
- in_pred_taken  in  1  front-end direction prediction.
- in_pred_target  in  XLEN  front-end predicted target.
- res_valid  out  1  queue head valid.
- res_ready  in  1  consumer takes the head.
- res_tag  out  TAGW  tag of the head.
- res_taken  out  1  actual outcome (always 1 for jumps).
- res_miss  out  1  head was mispredicted.
- res_correct_pc  out  XLEN  architecturally correct next PC.
- res_is_jump  out  1  head is JAL/JALR.
- res_link  out  XLEN  pc+4 link value; 0 for branches.
- btb_update  out  1  single-cycle BTB write strobe.
- btb_pc, btb_target  out  XLEN  branch PC and taken target pc+imm.
- btb_taken  out  1  actual outcome written to the BTB.

## Operation
- Accept on in_valid && in_ready. in_ready = (count < DEPTH) && !flush && !squash, where squash = res_valid && res_ready && res_miss.
- Branch compare: BEQ/BNE use a==b; BLT/BGE use signed a<b; BLTU/BGEU use unsigned a<b. BNE, BGE and BGEU invert the result. An unknown type is not taken.
- Branch: correct_pc = taken ? pc+imm : pc+4 (mod 2^XLEN). miss = taken != pred_taken.
- JAL: correct_pc = pc+imm. JALR: correct_pc = (a+imm) & ~1. Both set link = pc+4. j_type 3 gives correct_pc = pc+4, taken = 0, miss = 0.
- The resolved entry is written at the tail. For a branch, the BTB fields are registered and btb_update pulses for one cycle. Jumps never write the BTB.
- Head pop on res_valid && res_ready. Pop and push may occur in the same cycle; count is unchanged.
- Squash (popping a missed head): all remaining entries are discarded. Any op presented that cycle is refused (in_ready=0).
- flush: the queue is emptied next edge; no accept that cycle. A btb_update already registered still fires.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.

## Timing
- Reset: queue empty, res_valid=0, in_ready=1, btb_update=0. All data outputs are 0.
- Latency: accepted at edge N → res_valid and btb_update at N+1 if the queue was empty. Otherwise the entry waits behind older entries.
- Throughput: 1 op/cycle while not full.
- Full: in_ready=0 even if res_ready=1 that cycle; there is no bypass.
- res_* fields are stable while res_valid && !res_ready.
- Reset mid-operation clears everything asynchronously; no pending btb_update survives.

## Configuration
- BR_TARGET_CHECK_EN defined: a taken op (branch or jump) also misses when pred_target != correct_pc. A correctly predicted not-taken branch ignores pred_target.
- Undefined: branches miss on direction only, and jumps never miss.

## Test plan
- BEQ with pc=0x100, a=b=5, imm=0x20, pred_taken=0 → one cycle later: res_taken=1, res_miss=1, correct_pc=0x120, btb_update=1, btb_target=0x120.
- BLTU with a=0xFFFFFFFF, b=1 vs BLT with the same operands → unsigned not taken (correct_pc=pc+4); signed taken.
- JALR with a=0x1003, imm=4, pc=0x200 → correct_pc=0x1006, res_link=0x204, btb_update=0. With the macro and pred_target=0x1000: res_miss=1. Without the macro: res_miss=0.
- Fill DEPTH=4 with res_ready=0 → in_ready=0 at count 4. Then res_ready=1 for one cycle → pop; in_ready returns next cycle. Tags emerge in order.
- Queue holds 3 entries, head mispredicted, res_ready=1 with in_valid=1 → next cycle res_valid=0, count=0, and the new op is not accepted.
- flush asserted with 2 entries queued and a push pending → queue empty next cycle; the prior btb_update still pulses exactly once.

Source files
------------

// File: rtl/fu_branch_pipe.sv
// rtl/fu_branch_pipe.sv - branch/jump resolve stage with in-order result queue; BR_TARGET_CHECK_EN adds target-mismatch misprediction
module fu_branch_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TAGW-1:0] in_tag,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_reg_a,
    input  logic [XLEN-1:0] in_reg_b,
    input  logic [XLEN-1:0] in_imm,
    input  logic [2:0]      in_branch_type,
    input  logic [1:0]      in_j_type,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [TAGW-1:0] res_tag,
    output logic            res_taken,
    output logic            res_miss,
    output logic [XLEN-1:0] res_correct_pc,
    output logic            res_is_jump,
    output logic [XLEN-1:0] res_link,
    output logic            btb_update,
    output logic [XLEN-1:0] btb_pc,
    output logic [XLEN-1:0] btb_target,
    output logic            btb_taken
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    localparam logic [2:0] BT_BEQ  = 3'd0;
    localparam logic [2:0] BT_BNE  = 3'd1;
    localparam logic [2:0] BT_BLT  = 3'd2;
    localparam logic [2:0] BT_BGE  = 3'd3;
    localparam logic [2:0] BT_BLTU = 3'd4;
    localparam logic [2:0] BT_BGEU = 3'd5;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic            taken;
        logic            miss;
        logic [XLEN-1:0] correct_pc;
        logic            is_jump;
        logic [XLEN-1:0] link;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          res_in;
    entry_t          head_e;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count;
    logic            cmp;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] tgt_pc;
    logic            push;
    logic            pop;
    logic            squash;
    logic            is_branch;

    assign seq_pc    = in_pc + XLEN'(4);
    assign tgt_pc    = in_pc + in_imm;
    assign is_branch = (in_j_type == 2'd0);

    always_comb begin
        cmp = 1'b0;
        case (in_branch_type)
            BT_BEQ:  cmp = (in_reg_a == in_reg_b);
            BT_BNE:  cmp = (in_reg_a != in_reg_b);
            BT_BLT:  cmp = ($signed(in_reg_a) < $signed(in_reg_b));
            BT_BGE:  cmp = !($signed(in_reg_a) < $signed(in_reg_b));
            BT_BLTU: cmp = (in_reg_a < in_reg_b);
            BT_BGEU: cmp = !(in_reg_a < in_reg_b);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        res_in     = '0;
        res_in.tag = in_tag;
        case (in_j_type)
            2'd0: begin
                res_in.taken      = cmp;
                res_in.correct_pc = cmp ? tgt_pc : seq_pc;
                res_in.miss       = (cmp != in_pred_taken);
`ifdef BR_TARGET_CHECK_EN
                if (cmp && (in_pred_target != tgt_pc))
                    res_in.miss = 1'b1;
`endif
            end
            2'd1, 2'd2: begin
                res_in.taken      = 1'b1;
                res_in.is_jump    = 1'b1;
                res_in.link       = seq_pc;
                res_in.correct_pc = (in_j_type == 2'd1) ? tgt_pc
                                  : ((in_reg_a + in_imm) & ~XLEN'(1));
`ifdef BR_TARGET_CHECK_EN
                res_in.miss       = (in_pred_target != res_in.correct_pc);
`endif
            end
            default: res_in.correct_pc = seq_pc;
        endcase
    end

`ifndef BR_TARGET_CHECK_EN
    logic unused_pred_target;
    assign unused_pred_target = ^in_pred_target;
`endif

    // Idle outputs read as zero so consumers never see stale entries.
    assign head_e    = (count != '0) ? mem[head] : '0;
    assign res_valid = (count != '0);
    assign squash    = res_valid && res_ready && head_e.miss;
    assign in_ready  = (count < FULL) && !flush && !squash;
    assign push      = in_valid && in_ready;
    assign pop       = res_valid && res_ready;

    assign res_tag        = head_e.tag;
    assign res_taken      = head_e.taken;
    assign res_miss       = head_e.miss;
    assign res_correct_pc = head_e.correct_pc;
    assign res_is_jump    = head_e.is_jump;
    assign res_link       = head_e.link;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush || squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= res_in;
                tail      <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // BTB strobe is independent of flush: a registered update always fires.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            btb_update <= 1'b0;
            btb_pc     <= '0;
            btb_target <= '0;
            btb_taken  <= 1'b0;
        end else begin
            btb_update <= push && is_branch;
            if (push && is_branch) begin
                btb_pc     <= in_pc;
                btb_target <= tgt_pc;
                btb_taken  <= cmp;
            end
        end
    end
endmodule

// File: tb/tb_fu_branch_pipe.sv
// tb/tb_fu_branch_pipe.sv - randomized bench for fu_branch_pipe against a queue-based reference model
module tb_fu_branch_pipe;
`ifdef BR_TARGET_CHECK_EN
    localparam bit TCHK = 1'b1;
`else
    localparam bit TCHK = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [31:0] in_pc;
    logic [31:0] in_reg_a;
    logic [31:0] in_reg_b;
    logic [31:0] in_imm;
    logic [2:0]  in_branch_type;
    logic [1:0]  in_j_type;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_tag;
    logic        res_taken;
    logic        res_miss;
    logic [31:0] res_correct_pc;
    logic        res_is_jump;
    logic [31:0] res_link;
    logic        btb_update;
    logic [31:0] btb_pc;
    logic [31:0] btb_target;
    logic        btb_taken;

    fu_branch_pipe #(.XLEN(32), .DEPTH(4), .TAGW(4)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_pc(in_pc),
        .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_imm(in_imm),
        .in_branch_type(in_branch_type), .in_j_type(in_j_type),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res_taken(res_taken), .res_miss(res_miss), .res_correct_pc(res_correct_pc),
        .res_is_jump(res_is_jump), .res_link(res_link),
        .btb_update(btb_update), .btb_pc(btb_pc), .btb_target(btb_target),
        .btb_taken(btb_taken)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  tag;
        logic        taken;
        logic        miss;
        logic [31:0] cpc;
        logic        jump;
        logic [31:0] link;
    } exp_t;

    exp_t        q[$];
    logic        b_valid;
    logic [31:0] b_pc;
    logic [31:0] b_tgt;
    logic        b_taken;
    int          total  = 0;
    int          passed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else
            passed++;
    endtask

    function automatic exp_t resolve(input logic [3:0] tag, input logic [31:0] pc, a, b, imm,
                                     input logic [2:0] bt, input logic [1:0] jt,
                                     input logic pt, input logic [31:0] ptgt);
        exp_t e;
        logic t;
        e = '{tag: tag, taken: 1'b0, miss: 1'b0, cpc: pc + 32'd4, jump: 1'b0, link: 32'd0};
        case (bt)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd2: t = ($signed(a) < $signed(b));
            3'd3: t = ($signed(a) >= $signed(b));
            3'd4: t = (a < b);
            3'd5: t = (a >= b);
            default: t = 1'b0;
        endcase
        if (jt == 2'd0) begin
            e.taken = t;
            if (t) e.cpc = pc + imm;
            e.miss = (t != pt) || (TCHK && t && (ptgt != e.cpc));
        end else if (jt != 2'd3) begin
            e.taken = 1'b1;
            e.jump  = 1'b1;
            e.link  = pc + 32'd4;
            e.cpc   = (jt == 2'd1) ? pc + imm : ((a + imm) & 32'hFFFF_FFFE);
            e.miss  = TCHK && (ptgt != e.cpc);
        end
        return e;
    endfunction

    // Caller sets inputs at the falling edge; this checks, clocks and advances the model.
    task automatic step();
        logic m_squash, m_ready, m_acc, m_pop;
        exp_t e;
        #1;
        m_squash = (q.size() != 0) && res_ready && q[0].miss;
        m_ready  = (q.size() < 4) && !flush && !m_squash;
        check("in_ready", in_ready, m_ready);
        check("res_valid", res_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("res_tag", res_tag, q[0].tag);
            check("res_taken", res_taken, q[0].taken);
            check("res_miss", res_miss, q[0].miss);
            check("res_correct_pc", res_correct_pc, q[0].cpc);
            check("res_is_jump", res_is_jump, q[0].jump);
            check("res_link", res_link, q[0].link);
        end else begin
            check("res_correct_pc_idle", res_correct_pc, 32'd0);
        end
        check("btb_update", btb_update, b_valid);
        if (b_valid) begin
            check("btb_pc", btb_pc, b_pc);
            check("btb_target", btb_target, b_tgt);
            check("btb_taken", btb_taken, b_taken);
        end
        m_acc = in_valid && m_ready;
        m_pop = (q.size() != 0) && res_ready;
        e = resolve(in_tag, in_pc, in_reg_a, in_reg_b, in_imm, in_branch_type, in_j_type,
                    in_pred_taken, in_pred_target);
        @(posedge CLK);
        b_valid = m_acc && (in_j_type == 2'd0);
        b_pc    = in_pc;
        b_tgt   = in_pc + in_imm;
        b_taken = e.taken;
        if (flush || m_squash) begin
            q.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (m_acc) q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic set_op(input logic [3:0] tag, input logic [31:0] pc, a, b, imm,
                          input logic [2:0] bt, input logic [1:0] jt,
                          input logic pt, input logic [31:0] ptgt);
        in_valid = 1'b1; in_tag = tag; in_pc = pc; in_reg_a = a; in_reg_b = b;
        in_imm = imm; in_branch_type = bt; in_j_type = jt;
        in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    task automatic rand_op();
        logic [31:0] r;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] a;
        r   = $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        imm = {{20{r[11]}}, r[11:0]};
        a   = $urandom;
        set_op(4'($urandom), pc, a, ($urandom_range(0, 2) == 0) ? a : $urandom, imm,
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 0) ? pc + imm : $urandom);
        in_valid = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; res_ready = 1'b0;
        set_op(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        in_valid = 1'b0;
        b_valid = 1'b0; b_pc = '0; b_tgt = '0; b_taken = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_res_valid", res_valid, 1'b0);
        check("reset_btb_update", btb_update, 1'b0);
        check("reset_res_link", res_link, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        set_op(4'd1, 32'h100, 32'd5, 32'd5, 32'h20, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        in_valid = 1'b0;
        check("beq_taken", res_taken, 1'b1);
        check("beq_miss", res_miss, 1'b1);
        check("beq_cpc", res_correct_pc, 32'h120);
        check("beq_btb_update", btb_update, 1'b1);
        check("beq_btb_target", btb_target, 32'h120);
        res_ready = 1'b1;
        step();

        res_ready = 1'b0;
        set_op(4'd2, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'd4, 2'd0, 1'b0, 32'd0);
        step();
        check("bltu_taken", res_taken, 1'b0);
        check("bltu_cpc", res_correct_pc, 32'h304);
        res_ready = 1'b1;
        set_op(4'd3, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'd2, 2'd0, 1'b0, 32'd0);
        step();
        in_valid = 1'b0;
        check("blt_taken", res_taken, 1'b1);
        check("blt_cpc", res_correct_pc, 32'h340);
        step();

        res_ready = 1'b0;
        set_op(4'd4, 32'h200, 32'h1003, 32'd0, 32'd4, 3'd0, 2'd2, 1'b1, 32'h1000);
        step();
        in_valid = 1'b0;
        check("jalr_cpc", res_correct_pc, 32'h1006);
        check("jalr_link", res_link, 32'h204);
        check("jalr_btb_update", btb_update, 1'b0);
        check("jalr_miss", res_miss, TCHK);
        res_ready = 1'b1;
        step();

        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_op(4'(i + 8), 32'h400 + 32'(i * 4), 32'd1, 32'd2, 32'h10, 3'd0, 2'd0, 1'b0, 32'd0);
            step();
        end
        check("full_in_ready", in_ready, 1'b0);
        res_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("after_pop_in_ready", in_ready, 1'b1);
        repeat (4) step();

        res_ready = 1'b0;
        set_op(4'd5, 32'h500, 32'd7, 32'd7, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        set_op(4'd6, 32'h504, 32'd7, 32'd8, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        set_op(4'd7, 32'h508, 32'd7, 32'd8, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        res_ready = 1'b1;
        set_op(4'd9, 32'h50C, 32'd7, 32'd8, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        check("squash_res_valid", res_valid, 1'b0);

        res_ready = 1'b0;
        set_op(4'd10, 32'h600, 32'd1, 32'd2, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        set_op(4'd11, 32'h604, 32'd1, 32'd2, 32'h8, 3'd1, 2'd0, 1'b1, 32'h60C);
        step();
        flush = 1'b1;
        set_op(4'd12, 32'h608, 32'd1, 32'd2, 32'h8, 3'd0, 2'd0, 1'b0, 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_res_valid", res_valid, 1'b0);
        check("flush_btb_once", btb_update, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            rand_op();
            res_ready = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end

        flush = 1'b1; in_valid = 1'b0;
        step();
        flush = 1'b0;
        set_op(4'd13, 32'h700, 32'd3, 32'd3, 32'h10, 3'd0, 2'd0, 1'b1, 32'h710);
        step();
        in_valid = 1'b0;
        #2 nRST = 1'b0;
        #1;
        check("async_rst_res_valid", res_valid, 1'b0);
        check("async_rst_btb_update", btb_update, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        q.delete();
        b_valid = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
